reg_write_sequencer: RTL
========================

# reg_write_sequencer

Multicycle writeback controller for the register-file write port. It accepts one decoded writeback request from the main control FSM and drives the destination-select code into the register-destination mux. It also drives the write-data select and the register-file write enable over one or two cycles. Two-write instructions (POP) and hold/stall are sequenced here, so the main FSM issues a single request per instruction.

## Interface
Parameters: none; all encodings below are fixed.

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- wb_req  in  1  writeback request; sampled only in IDLE
- wb_kind  in  3  request class, captured on accept: 000 R-type, 001 I-type ALU, 010 LOAD, 011 JAL, 100 PUSH, 101 POP, 110/111 illegal
- wb_hold  in  1  stall: suppresses the write and freezes the state in W1/W2
- RegControl  out  3  destination-mux select: 000 instr[20:16] (rt), 001 instr[25:21] (rs), 010 const 29, 011 const 31, 100 instr[15:11] (rd)
- DataSel  out  2  write-data mux select: 00 ALUOut, 01 MDR, 10 PC; 11 never driven
- RegWrite  out  1  register-file write enable
- wb_busy  out  1  high in every non-IDLE state
- wb_done  out  1  one-cycle pulse in the final cycle of a request
- wb_err  out  1  one-cycle pulse for an illegal wb_kind

## Operation
- States are IDLE, W1, W2 and ERR, held in a registered FSM. Outputs are registered and decoded from the state and the captured kind.
- IDLE: a request is accepted when wb_req=1. A legal kind moves the FSM to W1; kind 110/111 moves it to ERR. Accepting latches wb_kind into kind_q.
- W1 write per kind (RegControl / DataSel):
  - R: 100 / 00
  - I: 000 / 00
  - LOAD: 000 / 01
  - JAL: 011 / 10
  - PUSH: 010 / 00 (SP-4 from ALU)
  - POP: 000 / 01 (rt <- MDR)
- W1 exit: POP moves to W2. Every other kind asserts wb_done and moves to IDLE.
- W2 (POP only): RegControl=010, DataSel=00 (SP+4 from ALU). Asserts wb_done and moves to IDLE.
- ERR: wb_err=1 and wb_done=1 for one cycle, RegWrite=0, then IDLE.
- RegWrite=1 in W1/W2 only when wb_hold=0.
- Hold: with wb_hold=1 in W1/W2, RegWrite=0 and wb_done=0. State, RegControl and DataSel are unchanged. The write completes in the first cycle with wb_hold=0.
- wb_req outside IDLE is ignored. No queuing; the requester waits for wb_done and then issues its next request.
- In IDLE, RegWrite=0, wb_done=0 and wb_err=0, and RegControl/DataSel hold their last values.

## Timing
- Reset values: state IDLE, RegControl=000, DataSel=00, RegWrite=0, wb_busy=0, wb_done=0, wb_err=0, kind_q=000.
- Latency: request accepted at edge N means the write cycle (RegWrite=1) is cycle N+1 with no hold. POP's second write is cycle N+2.
- wb_done is coincident with the last RegWrite=1 cycle. The earliest next acceptance is the edge ending the first IDLE cycle after wb_done.
- Back-to-back throughput, no hold: one single-write request every 2 cycles; POP every 3.
- Reset mid-operation (W1 with hold, or W2) returns to IDLE immediately with all outputs at reset values. The pending write, including POP's SP update, is dropped with no wb_done.
- wb_hold has no effect in IDLE or ERR.
- Outputs change only on clk edges, or asynchronously on reset assertion.

## Test plan
- Reset: assert reset mid-cycle -> all outputs 0 immediately. Deassert, idle 3 cycles -> RegWrite stays 0.
- R, then JAL, no hold: wb_req with kind 000 -> next cycle RegControl=100, DataSel=00, RegWrite=1, wb_done=1. Then kind 011 -> RegControl=011, DataSel=10, one write.
- POP: kind 101 -> cycle+1 RegControl=000, DataSel=01, RegWrite=1, wb_done=0. Cycle+2 RegControl=010, DataSel=00, RegWrite=1, wb_done=1. Exactly 2 writes.
- Hold: LOAD with wb_hold=1 for 3 cycles -> RegWrite=0, wb_busy=1, RegControl=000, DataSel=01 stable. Hold release -> single write plus wb_done.
- Illegal: kind 111 -> one cycle wb_err=1, wb_done=1, RegWrite=0, then IDLE. wb_req raised during busy is ignored, so no extra write is counted.
- Reset in W2 of a POP -> no second write and no wb_done. The next PUSH gives RegControl=010, DataSel=00, one write.

Source files
------------

// File: rtl/reg_write_sequencer.sv
// Register-file writeback sequencer: turns one request into one or two write cycles.
// Latency: write cycle N+1 after the accepting edge N (POP second write at N+2).
// Backpressure: wb_hold freezes W1/W2 with the write suppressed; wb_req is ignored outside IDLE.
//
// wb_hold is sampled at the clock edge that opens a write cycle. Every output is a
// flop, so the write enable for a cycle is decided at the edge that starts that
// cycle. A cycle that opened with wb_hold=1 performs no write. The FSM stays in
// W1/W2 until a cycle that actually wrote (regwrite_q=1) has elapsed.
module reg_write_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       wb_req,
  input  logic [2:0] wb_kind,
  input  logic       wb_hold,
  output logic [2:0] RegControl,
  output logic [1:0] DataSel,
  output logic       RegWrite,
  output logic       wb_busy,
  output logic       wb_done,
  output logic       wb_err
);

  // Request classes
  localparam logic [2:0] KIND_R    = 3'b000;
  localparam logic [2:0] KIND_I    = 3'b001;
  localparam logic [2:0] KIND_LOAD = 3'b010;
  localparam logic [2:0] KIND_JAL  = 3'b011;
  localparam logic [2:0] KIND_PUSH = 3'b100;
  localparam logic [2:0] KIND_POP  = 3'b101;

  // Destination-mux select codes
  localparam logic [2:0] RC_RT   = 3'b000;
  localparam logic [2:0] RC_RS   = 3'b001;
  localparam logic [2:0] RC_SP   = 3'b010;
  localparam logic [2:0] RC_RA   = 3'b011;
  localparam logic [2:0] RC_RD   = 3'b100;

  // Write-data mux select codes
  localparam logic [1:0] DS_ALU  = 2'b00;
  localparam logic [1:0] DS_MDR  = 2'b01;
  localparam logic [1:0] DS_PC   = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    W1   = 2'b01,
    W2   = 2'b10,
    ERR  = 2'b11
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] kind_q, kind_d;
  logic [2:0] regctl_q, regctl_d;
  logic [1:0] datasel_q, datasel_d;
  logic       regwrite_q, regwrite_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       kind_illegal;

  // Kinds 110 and 111 have no writeback meaning.
  assign kind_illegal = wb_kind[2] & wb_kind[1];

  // Next state, captured kind and the registered output values for the coming cycle.
  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    regctl_d   = regctl_q;
    datasel_d  = datasel_q;
    regwrite_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (wb_req) begin
          kind_d  = wb_kind;
          state_d = kind_illegal ? ERR : W1;
        end
      end
      W1: begin
        // Leave only after a cycle that really wrote; a held cycle repeats.
        if (regwrite_q) begin
          state_d = (kind_q == KIND_POP) ? W2 : IDLE;
        end
      end
      W2: begin
        if (regwrite_q) begin
          state_d = IDLE;
        end
      end
      ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    case (state_d)
      W1: begin
        busy_d     = 1'b1;
        regwrite_d = ~wb_hold;
        done_d     = ~wb_hold & (kind_d != KIND_POP);
        case (kind_d)
          KIND_R:    begin regctl_d = RC_RD; datasel_d = DS_ALU; end
          KIND_I:    begin regctl_d = RC_RT; datasel_d = DS_ALU; end
          KIND_LOAD: begin regctl_d = RC_RT; datasel_d = DS_MDR; end
          KIND_JAL:  begin regctl_d = RC_RA; datasel_d = DS_PC;  end
          KIND_PUSH: begin regctl_d = RC_SP; datasel_d = DS_ALU; end
          KIND_POP:  begin regctl_d = RC_RT; datasel_d = DS_MDR; end
          default:   begin regctl_d = regctl_q; datasel_d = datasel_q; end
        endcase
      end
      W2: begin
        // POP stack-pointer update: SP+4 from the ALU.
        busy_d     = 1'b1;
        regwrite_d = ~wb_hold;
        done_d     = ~wb_hold;
        regctl_d   = RC_SP;
        datasel_d  = DS_ALU;
      end
      ERR: begin
        busy_d = 1'b1;
        done_d = 1'b1;
        err_d  = 1'b1;
      end
      default: begin
        // IDLE: mux selects keep their last values, strobes stay low.
        busy_d = 1'b0;
      end
    endcase
  end

  // State, captured kind and all outputs are registered; reset drops any pending write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      kind_q     <= 3'b000;
      regctl_q   <= 3'b000;
      datasel_q  <= 2'b00;
      regwrite_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      regctl_q   <= regctl_d;
      datasel_q  <= datasel_d;
      regwrite_q <= regwrite_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // The rs select code exists in the mux but no request class uses it.
  logic unused_rs;
  assign unused_rs = ^RC_RS;

  assign RegControl = regctl_q;
  assign DataSel    = datasel_q;
  assign RegWrite   = regwrite_q;
  assign wb_busy    = busy_q;
  assign wb_done    = done_q;
  assign wb_err     = err_q;

endmodule
